// File: rtl/systolic_operand_feeder.sv
// Operand feeder for the PE array: streams K words from an operand SRAM and
// applies the triangular lane skew (lane i delayed i cycles) with global stall.
module sof_lane #(
    parameter int W   = 8,
    parameter int DLY = 0
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         en,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);
    logic [DLY:0][W-1:0] dat_pipe;
    logic [DLY:0]        vld_pipe;

    // Invalid slots carry zero so the PE accumulates nothing.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dat_pipe <= '0;
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe[0] <= in_vld;
            dat_pipe[0] <= in_vld ? in_data : '0;
            for (int k = 1; k <= DLY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign out_vld  = vld_pipe[DLY];
    assign out_data = dat_pipe[DLY];
endmodule

module systolic_operand_feeder #(
    parameter int OPND_BWIDTH     = 8,
    parameter int NUM_LANES       = 4,
    parameter int SRAM_AWIDTH     = 10,
    parameter int MAX_K_SIZE_LOG2 = 9
) (
    input  logic                             CLK,
    input  logic                             RSTn,
    input  logic                             START,
    input  logic                             STALL,
    input  logic [SRAM_AWIDTH-1:0]           BASE_ADDR_in,
    input  logic [MAX_K_SIZE_LOG2-1:0]       K_SIZE_in,
    output logic                             SRAM_RD_EN_out,
    output logic [SRAM_AWIDTH-1:0]           SRAM_ADDR_out,
    input  logic [NUM_LANES*OPND_BWIDTH-1:0] SRAM_RDATA_in,
    output logic [NUM_LANES*OPND_BWIDTH-1:0] DATA_out,
    output logic [NUM_LANES-1:0]             VALID_out,
    output logic                             BUSY_out,
    output logic                             DONE_out
);
    localparam int DW  = NUM_LANES * OPND_BWIDTH;
    localparam int DCW = $clog2(NUM_LANES + 1);
    localparam logic [DCW-1:0] DLAST = DCW'(NUM_LANES);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                     state;
    logic [SRAM_AWIDTH-1:0]     addr_q;
    logic [MAX_K_SIZE_LOG2-1:0] k_q;
    logic [MAX_K_SIZE_LOG2-1:0] wcnt;
    logic [DCW-1:0]             dcnt;
    logic                       rd_pend;
    logic                       skid_vld;
    logic [DW-1:0]              skid_q;
    logic                       adv;
    logic                       lane_in_vld;
    logic [DW-1:0]              lane_in_data;

    assign adv            = ~STALL;
    assign SRAM_RD_EN_out = (state == S_READ) && adv;
    assign SRAM_ADDR_out  = addr_q;
    assign BUSY_out       = (state != S_IDLE);
    assign DONE_out       = (state == S_DONE) && adv;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= S_IDLE;
            addr_q <= '0;
            k_q    <= '0;
            wcnt   <= '0;
            dcnt   <= '0;
        end else if (adv) begin
            case (state)
                S_IDLE: if (START) begin
                    if (K_SIZE_in == '0) begin
                        state <= S_DONE;
                    end else begin
                        addr_q <= BASE_ADDR_in;
                        k_q    <= K_SIZE_in;
                        wcnt   <= '0;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    addr_q <= addr_q + 1'b1;
                    wcnt   <= wcnt + 1'b1;
                    if (wcnt == k_q - 1'b1) begin
                        dcnt  <= '0;
                        state <= S_DRAIN;
                    end
                end
                // Runs until the deepest lane has emitted the last word.
                S_DRAIN: begin
                    if (dcnt == DLAST) state <= S_DONE;
                    else               dcnt  <= dcnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data is only present for one cycle; park it if that cycle stalls.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_pend  <= 1'b0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else begin
            rd_pend <= SRAM_RD_EN_out;
            if (!adv && rd_pend) begin
                skid_vld <= 1'b1;
                skid_q   <= SRAM_RDATA_in;
            end else if (adv) begin
                skid_vld <= 1'b0;
            end
        end
    end

    assign lane_in_vld  = skid_vld | rd_pend;
    assign lane_in_data = skid_vld ? skid_q : SRAM_RDATA_in;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sof_lane #(.W(OPND_BWIDTH), .DLY(i)) u_lane (
            .CLK      (CLK),
            .RSTn     (RSTn),
            .en       (adv),
            .in_vld   (lane_in_vld),
            .in_data  (lane_in_data[i*OPND_BWIDTH +: OPND_BWIDTH]),
            .out_vld  (VALID_out[i]),
            .out_data (DATA_out[i*OPND_BWIDTH +: OPND_BWIDTH])
        );
    end
endmodule
